// File: rtl/exe_muldiv_unit_pkg.sv
// Shared types and constants for the execute-stage RV32M multiply/divide unit.
package exe_muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;

    // Divide-by-zero quotient and the signed minimum that produces DIV overflow.
    localparam logic [MD_WIDTH-1:0] MD_DIV0_QUOT = {MD_WIDTH{1'b1}};
    localparam logic [MD_WIDTH-1:0] MD_SMIN      = {1'b1, {(MD_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// Execute-stage operand/control inputs and result/stall outputs of the mul/div unit.
interface exe_muldiv_unit_if
    import exe_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             StartE;
    logic [2:0]       MulDivOpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [4:0]       RdE;
    logic             FlushE;

    // No valid/ready pair: StartE is held by the pipeline while StallMD is high,
    // and ValidMD is a one-cycle strobe the writeback mux must take when it fires.
    logic             StallMD;
    logic [WIDTH-1:0] ResultMD;
    logic             ValidMD;
    logic [4:0]       RdMD;
    muldiv_state_e    StateMD;

    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
        input  StallMD, ResultMD, ValidMD, RdMD, StateMD
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
        output StallMD, ResultMD, ValidMD, RdMD, StateMD
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction in DONE.
module exe_muldiv_unit
    import exe_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    exe_muldiv_unit_if.slave md
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    muldiv_op_e         op_q, op_d;
    logic [4:0]         rd_q, rd_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    muldiv_op_e       op_in;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf, accept;

    assign op_in    = muldiv_op_e'(md.MulDivOpE);
    assign sign_a   = op_a_signed(op_in) & md.SrcAE[WIDTH-1];
    assign sign_b   = op_b_signed(op_in) & md.SrcBE[WIDTH-1];
    assign mag_a    = sign_a ? -md.SrcAE : md.SrcAE;
    assign mag_b    = sign_b ? -md.SrcBE : md.SrcBE;
    assign div_zero = op_is_div(op_in) && (md.SrcBE == '0);
    assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (md.SrcAE == SMIN) && (md.SrcBE == ALL_ONES);
    assign accept   = (state_q == S_IDLE) && md.StartE && !md.FlushE;

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0] mul_sum, div_trial, div_diff;
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, opnd_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = op_in;
                    rd_d  = md.RdE;
                    cnt_d = '0;
                    if (div_zero) begin
                        // Quotient half all ones, remainder half the raw dividend.
                        acc_d   = {md.SrcAE, ALL_ONES};
                        neg_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        acc_d   = {{WIDTH{1'b0}}, SMIN};
                        neg_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, op_is_div(op_in) ? mag_a : mag_b};
                        opnd_d  = op_is_div(op_in) ? mag_b : mag_a;
                        neg_d   = op_is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_is_div(op_q)) begin
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (md.FlushE)
            state_d = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
        end
    end

    // Products negate the full double-width value; quotient/remainder negate their half only.
    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH-1:0]   div_sel, div_res, res;
    assign mul_full = neg_q ? -acc_q : acc_q;
    assign div_sel  = (op_q inside {OP_DIV, OP_DIVU}) ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
    assign div_res  = neg_q ? -div_sel : div_sel;

    always_comb begin
        res = '0;
        unique case (op_q)
            OP_MUL:                         res = mul_full[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   res = mul_full[2*WIDTH-1:WIDTH];
            default:                        res = div_res;
        endcase
    end

    assign md.ValidMD  = (state_q == S_DONE);
    assign md.ResultMD = md.ValidMD ? res : '0;
    assign md.RdMD     = md.ValidMD ? rd_q : '0;
    assign md.StallMD  = accept || (state_q == S_BUSY);
    assign md.StateMD  = state_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed and randomized checks of exe_muldiv_unit against an arithmetic reference.
module tb_exe_muldiv_unit;
    import exe_muldiv_unit_pkg::*;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    exe_muldiv_unit_if #(.WIDTH(W)) md();

    exe_muldiv_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .md    (md)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    // Reference: RV32M results from 64-bit integer arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        int         ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return MD_DIV0_QUOT;
                if (a == MD_SMIN && b == MD_DIV0_QUOT) return MD_SMIN;
                return W'(ia / ib);
            end
            3'd5: return (b == 0) ? MD_DIV0_QUOT : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MD_SMIN && b == MD_DIV0_QUOT) return '0;
                return W'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Driver: present one op at a negedge, hold StartE like a stalled pipeline
    // through the DONE edge, then release it.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
        logic [W-1:0] expv;
        int lat, exp_lat;
        bit fast;
        exp_q.push_back(ref_model(op, a, b));
        fast = (op >= 3'd4 && b == 0) || ((op == 3'd4 || op == 3'd6) && a == MD_SMIN && b == MD_DIV0_QUOT);
        exp_lat = fast ? 1 : W + 1;
        md.StartE    = 1'b1;
        md.MulDivOpE = op;
        md.SrcAE     = a;
        md.SrcBE     = b;
        md.RdE       = rd;
        #1 check("stall_accept", W'(md.StallMD), W'(1));
        lat = -1;
        for (int c = 1; c <= W + 8; c++) begin
            @(negedge CLK);
            if (md.ValidMD) begin
                lat = c;
                break;
            end
            check("stall_busy", W'(md.StallMD), W'(1));
        end
        check("latency", W'(lat), W'(exp_lat));
        expv = exp_q.pop_front();
        check($sformatf("result_op%0d_a%h_b%h", op, a, b), md.ResultMD, expv);
        check("rd", W'(md.RdMD), W'(rd));
        check("stall_done", W'(md.StallMD), W'(0));
        @(negedge CLK);
        check("valid_single", W'(md.ValidMD), W'(0));
        check("idle_after_done", W'(md.StateMD), W'(S_IDLE));
        md.StartE = 1'b0;
    endtask

    initial begin
        int vcount;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        md.StartE    = 1'b0;
        md.MulDivOpE = '0;
        md.SrcAE     = '0;
        md.SrcBE     = '0;
        md.RdE       = '0;
        md.FlushE    = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_valid",  W'(md.ValidMD), W'(0));
        check("rst_result", md.ResultMD, W'(0));
        check("rst_rd",     W'(md.RdMD), W'(0));
        check("rst_stall",  W'(md.StallMD), W'(0));
        check("rst_state",  W'(md.StateMD), W'(S_IDLE));
        RST_N = 1'b1;
        @(negedge CLK);

        // Directed arithmetic and fast-path cases
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
        do_op(3'd5, 32'd100, 32'd7, 5'd11);
        do_op(3'd7, 32'd100, 32'd7, 5'd12);
        do_op(3'd5, 32'h1234, 32'd0, 5'd13);
        do_op(3'd7, 32'h1234, 32'd0, 5'd14);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        @(negedge CLK);

        // Flush at BUSY cycle 10, StartE still asserted
        md.StartE    = 1'b1;
        md.MulDivOpE = 3'd5;
        md.SrcAE     = 32'hFFFF_FFFF;
        md.SrcBE     = 32'd7;
        md.RdE       = 5'd20;
        repeat (10) @(negedge CLK);
        check("flush_busy_state", W'(md.StateMD), W'(S_BUSY));
        md.FlushE = 1'b1;
        @(negedge CLK);
        check("flush_valid", W'(md.ValidMD), W'(0));
        check("flush_stall", W'(md.StallMD), W'(0));
        check("flush_state", W'(md.StateMD), W'(S_IDLE));
        md.FlushE = 1'b0;
        md.StartE = 1'b0;
        vcount = 0;
        repeat (40) begin
            @(negedge CLK);
            if (md.ValidMD) vcount++;
        end
        check("flush_no_valid", W'(vcount), W'(0));
        do_op(3'd5, 32'd9, 32'd3, 5'd21);

        // Async reset at BUSY cycle 5
        md.StartE    = 1'b1;
        md.MulDivOpE = 3'd0;
        md.SrcAE     = 32'h1234_5678;
        md.SrcBE     = 32'h9ABC_DEF0;
        md.RdE       = 5'd22;
        repeat (5) @(negedge CLK);
        RST_N     = 1'b0;
        md.StartE = 1'b0;
        #1;
        check("arst_valid",  W'(md.ValidMD), W'(0));
        check("arst_result", md.ResultMD, W'(0));
        check("arst_rd",     W'(md.RdMD), W'(0));
        check("arst_stall",  W'(md.StallMD), W'(0));
        check("arst_state",  W'(md.StateMD), W'(S_IDLE));
        @(negedge CLK);
        RST_N = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(negedge CLK);
            if (md.ValidMD) vcount++;
        end
        check("arst_no_valid", W'(vcount), W'(0));
        do_op(3'd0, 32'd3, 32'd4, 5'd23);

        // Randomized ops with biased corner operands
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = MD_SMIN; rb = MD_DIV0_QUOT; end
                2: rb = W'($urandom_range(1, 15));
                3: ra = W'($urandom_range(0, 15));
                4: rb = MD_SMIN;
                default: ;
            endcase
            do_op(rop, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
